// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stages.
package pipe_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IFID_W  = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } stage_state_e;

  function automatic logic [1:0] occ_of(stage_state_e s);
    case (s)
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_data_reg.sv
// WIDTH-bit payload register with load enable and async active-high clear.
module skid_data_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a main and a skid entry; in_ready is a pure flop output.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;
  logic             in_fire, out_fire;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_din;
  logic [WIDTH-1:0] main_q, skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_din = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_en  = 1'b1;
          main_din = skid_q;
          state_d  = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; payload regs keep their contents.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  skid_data_reg #(
    .WIDTH (WIDTH)
  ) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_din),
    .q   (main_q)
  );

  skid_data_reg #(
    .WIDTH (WIDTH)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed-vector bench for pipe_skid_stage with hand-computed expectations.
module tb_pipe_skid_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    check_vec({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check_vec({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
    check_vec({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Test 1: async reset mid-cycle, then a three-beat stream.
    #3 rst = 1'b1;
    #1;
    check_ctl("t1_rst", 1'b0, 1'b1, 2'd0);
    check_vec("t1_rst.out_data", 64'(out_data), 64'h0);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h100;
    out_ready = 1'b1;
    tick();
    check_vec("t1_b0", 64'(out_data), 64'h100);
    check_ctl("t1_b0", 1'b1, 1'b1, 2'd1);
    in_data = 32'h104;
    tick();
    check_vec("t1_b1", 64'(out_data), 64'h104);
    check_ctl("t1_b1", 1'b1, 1'b1, 2'd1);
    in_data = 32'h108;
    tick();
    check_vec("t1_b2", 64'(out_data), 64'h108);
    check_ctl("t1_b2", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_ctl("t1_drain", 1'b0, 1'b1, 2'd0);

    // Test 2: backpressure fill.
    in_valid  = 1'b1;
    in_data   = 32'hA;
    out_ready = 1'b0;
    tick();
    check_vec("t2_busy", 64'(out_data), 64'hA);
    check_ctl("t2_busy", 1'b1, 1'b1, 2'd1);
    in_data = 32'hB;
    tick();
    check_ctl("t2_full", 1'b1, 1'b0, 2'd2);
    check_vec("t2_full.out_data", 64'(out_data), 64'hA);
    in_data = 32'hC;
    tick();
    check_ctl("t2_hold", 1'b1, 1'b0, 2'd2);
    check_vec("t2_hold.out_data", 64'(out_data), 64'hA);

    // Test 3: drain order A (presented above), B, C.
    out_ready = 1'b1;
    tick();
    check_vec("t3_b", 64'(out_data), 64'hB);
    check_ctl("t3_b", 1'b1, 1'b1, 2'd1);
    tick();
    check_vec("t3_c", 64'(out_data), 64'hC);
    check_ctl("t3_c", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    check_ctl("t3_empty", 1'b0, 1'b1, 2'd0);

    // Test 4: flush while FULL with a pending 0xDEAD offer.
    in_valid  = 1'b1;
    in_data   = 32'h11;
    out_ready = 1'b0;
    tick();
    in_data = 32'h22;
    tick();
    check_ctl("t4_full", 1'b1, 1'b0, 2'd2);
    in_data = 32'hDEAD;
    flush   = 1'b1;
    tick();
    check_ctl("t4_flush", 1'b0, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_ctl("t4_after", 1'b0, 1'b1, 2'd0);
    check_vec("t4_after.out_data", 64'(out_data), 64'h11);

    // Test 5: simultaneous in/out fire in BUSY.
    in_valid  = 1'b1;
    in_data   = 32'h1;
    out_ready = 1'b0;
    tick();
    check_vec("t5_busy", 64'(out_data), 64'h1);
    check_ctl("t5_busy", 1'b1, 1'b1, 2'd1);
    in_data   = 32'h2;
    out_ready = 1'b1;
    tick();
    check_vec("t5_both", 64'(out_data), 64'h2);
    check_ctl("t5_both", 1'b1, 1'b1, 2'd1);

    // Test 6: async reset while FULL, between edges.
    out_ready = 1'b0;
    in_data   = 32'h3;
    tick();
    check_ctl("t6_full", 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_ctl("t6_rst", 1'b0, 1'b1, 2'd0);
    check_vec("t6_rst.out_data", 64'(out_data), 64'h0);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    tick();
    check_vec("t6_post", 64'(out_data), 64'h55);
    check_ctl("t6_post", 1'b1, 1'b1, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
